tx_rs232_fifo: RTL and testbench
================================

// Module: tx_rs232_fifo
// PURPOSE
//   RS232 transmitter. Buffers parallel words in a small FIFO and serialises each
//   as an 8N1-style frame: start(0), DATA_WIDTH bits LSB first, optional parity,
//   stop(1). Paired with the RS232 receiver as the TX half of the UART system.
//   Bit timing comes from an internal baud counter.
// PARAMETERS
//   BAUD_COUNT  434  clk cycles per serial bit (>=2); 50 MHz / 115200 baud
//   DATA_WIDTH  8    payload bits per frame (>=5)
//   FIFO_DEPTH  4    buffered words; power of 2, >=2
// PORTS
//   clk               in   1              system clock, rising edge
//   reset             in   1              asynchronous, active-low reset
//   tx_data           in   DATA_WIDTH     word to send; sampled when tx_valid & tx_ready
//   tx_valid          in   1              producer offers tx_data this cycle
//   tx_ready          out  1              FIFO can accept a word (count < FIFO_DEPTH)
//   serial_data_out   out  1              serial line; idle high
//   transmitting_flag out  1              high while a frame is on the line
//   frame_done        out  1              1-cycle pulse on the last cycle of a stop bit
//   fifo_count        out  $clog2(FIFO_DEPTH)+1  words currently buffered
// BEHAVIOUR
//   Reset (reset=0, async): serial_data_out=1, transmitting_flag=0, frame_done=0,
//     fifo_count=0, tx_ready=1, FSM=IDLE, baud counter=0. The line returns high
//     immediately, even mid-frame. The FIFO is flushed.
//   Push: on a rising edge with tx_valid & tx_ready, write tx_data. While the FIFO
//     is full, tx_valid is ignored and nothing is written.
//   The FIFO updates fifo_count on the same edge. Push and pop on the same edge
//     leave the count unchanged. Both pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
//   Baud counter: runs 0..BAUD_COUNT-1 in every non-IDLE state and clears on each
//     state/bit change. Every bit is held exactly BAUD_COUNT cycles.
//   IDLE: line=1, transmitting_flag=0. If fifo_count>0 on an edge: pop the head into
//     the shift register, go to START, drive line=0.
//     A word pushed into an empty FIFO at edge E0 is popped at E1. The start bit
//     begins after E1.
//   START -> DATA after BAUD_COUNT cycles. Bit index runs 0..DATA_WIDTH-1, LSB first.
//   DATA -> PARITY (or STOP) after bit DATA_WIDTH-1 completes.
//   STOP: line=1 for BAUD_COUNT cycles. frame_done=1 on the final cycle.
//     If the FIFO is non-empty on that final edge, pop and go directly to START.
//     No idle gap is inserted between frames.
//     Otherwise the FSM goes to IDLE and transmitting_flag falls.
//   transmitting_flag=1 exactly while the FSM is in START/DATA/PARITY/STOP.
//   Frame length: (DATA_WIDTH+2)*BAUD_COUNT cycles, +BAUD_COUNT with parity.
//   All outputs are registered; serial_data_out is glitch-free.
//   tx_data changes while tx_valid=0 have no effect.
// CONFIGURATION
//   TX_PARITY_EN defined: a PARITY bit is inserted after the data bits.
//     The parity bit is the even parity of the payload (XOR of all data bits).
//     The frame grows to DATA_WIDTH+3 bits.
//   TX_PARITY_EN undefined: there is no PARITY state; DATA goes straight to STOP.
//     The frame is DATA_WIDTH+2 bits.
// TESTING (BAUD_COUNT=4, DATA_WIDTH=8, FIFO_DEPTH=4 unless noted)
//   1. Reset asserted/released with tx_valid=0 -> line=1, tx_ready=1, fifo_count=0,
//      transmitting_flag=0 indefinitely.
//   2. Push 0xA5 once -> start bit begins 2 edges after the push.
//      Line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
//      frame_done pulses once at cycle 40 of the frame.
//   3. Push 0x00,0xFF,0x55 back-to-back -> three frames with no idle cycle between.
//      transmitting_flag stays high for 120 cycles.
//   4. Hold tx_valid=1 while the first frame is active -> after 4 further accepts,
//      fifo_count=4 and tx_ready=0. Extra words are dropped; exactly 5 frames are sent.
//   5. Assert reset during data bit 3 of 0x0F -> line=1 immediately, fifo_count=0.
//      After release, no frame is sent until a new push.
//   6. TX_PARITY_EN defined, push 0x07 -> parity bit=1, frame is 11 bits/44 cycles.
//      Push 0x03 -> parity bit=0.

Source files
------------

// File: rtl/tx_rs232_fifo.sv
// tx_rs232_fifo: FIFO-buffered RS232 transmitter (start, LSB-first data, stop); define TX_PARITY_EN for an even parity bit
module tx_rs232_fifo #(
    parameter int BAUD_COUNT = 434,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_data_out,
    output logic                        transmitting_flag,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_COUNT);
    localparam int IW = $clog2(DATA_WIDTH);
`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count_n;
    logic [BW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic push, pop, last, line_n, done_n;

    assign push    = tx_valid & tx_ready;
    assign last    = cnt == BW'(BAUD_COUNT - 1);
    assign count_n = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_n = state;
        cnt_n   = last ? '0 : cnt + 1'b1;
        idx_n   = idx;
        line_n  = serial_data_out;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    line_n  = 1'b0;
                end
            end
            START: if (last) begin
                state_n = DATA;
                idx_n   = '0;
                line_n  = data_q[0];
            end
            DATA: if (last) begin
                if (idx == IW'(DATA_WIDTH - 1)) begin
`ifdef TX_PARITY_EN
                    state_n = PARITY;
                    line_n  = ^data_q;
`else
                    state_n = STOP;
                    line_n  = 1'b1;
`endif
                end else begin
                    idx_n  = idx + 1'b1;
                    line_n = data_q[idx_n];
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (last) begin
                state_n = STOP;
                line_n  = 1'b1;
            end
`endif
            STOP: begin
                // frame_done is registered, so raise it one cycle ahead to land on the final stop cycle
                done_n = cnt == BW'(BAUD_COUNT - 2);
                if (last) begin
                    pop     = fifo_count != '0;
                    state_n = pop ? START : IDLE;
                    line_n  = !pop;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            idx               <= '0;
            data_q            <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            tx_ready          <= 1'b1;
            serial_data_out   <= 1'b1;
            transmitting_flag <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            idx               <= idx_n;
            serial_data_out   <= line_n;
            frame_done        <= done_n;
            transmitting_flag <= state_n != IDLE;
            fifo_count        <= count_n;
            tx_ready          <= count_n != (AW+1)'(FIFO_DEPTH);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_q <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= tx_data;
endmodule

// File: tb/tb_tx_rs232_fifo.sv
// tb_tx_rs232_fifo: directed and random stimulus checked every cycle against a frame-position reference model
module tb_tx_rs232_fifo;
    localparam int BAUD = 4;
    localparam int DW = 8;
    localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FL = NBITS * BAUD;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] tx_data;
    logic tx_valid;
    logic tx_ready, serial_data_out, transmitting_flag, frame_done;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] cur;
    bit busy = 1'b0;
    int pos = 0;

    tx_rs232_fifo #(.BAUD_COUNT(BAUD), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .serial_data_out(serial_data_out),
        .transmitting_flag(transmitting_flag),
        .frame_done(frame_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
`ifdef TX_PARITY_EN
        if (b == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // Reference: a queue of accepted words plus the cycle position inside the current frame
    always @(posedge clk or negedge reset) begin
        int n;
        bit psh, pp;
        if (!reset) begin
            q.delete();
            busy = 1'b0;
            pos = 0;
        end else begin
            n = q.size();
            psh = tx_valid && n < DEPTH;
            pp = n > 0 && (!busy || pos == FL - 1);
            if (pp) begin
                cur = q.pop_front();
                busy = 1'b1;
                pos = 0;
            end else if (busy && pos == FL - 1) busy = 1'b0;
            else if (busy) pos++;
            if (psh) q.push_back(tx_data);
        end
    end

    always @(negedge clk) begin
        chk("line", 32'(serial_data_out), busy ? 32'(frame_bit(cur, pos / BAUD)) : 32'd1);
        chk("tflag", 32'(transmitting_flag), 32'(busy));
        chk("done", 32'(frame_done), 32'(busy && pos == FL - 1));
        chk("count", 32'(fifo_count), 32'(q.size()));
        chk("ready", 32'(tx_ready), 32'(q.size() < DEPTH));
        if (frame_done) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        tx_valid = 1'b1;
        tx_data = d;
        @(negedge clk);
        #1 tx_valid = 1'b0;
        tx_data = DW'($urandom);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        #1;
        chk("rst_line", 32'(serial_data_out), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_tflag", 32'(transmitting_flag), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        idle(3);
        reset = 1'b1;
        idle(20);
        chk("idle_line", 32'(serial_data_out), 32'd1);
        push_word(8'hA5);
        idle(FL + 10);
        push_word(8'h00);
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        @(negedge clk);
        #1 tx_data = 8'h55;
        @(negedge clk);
        #1 tx_valid = 1'b0;
        idle(3 * FL + 10);
        done_cnt = 0;
        tx_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tx_data = DW'($urandom);
            if (i == 10) begin
                chk("flood_count", 32'(fifo_count), 32'd4);
                chk("flood_ready", 32'(tx_ready), 32'd0);
            end
            @(negedge clk);
            #1;
        end
        tx_valid = 1'b0;
        idle(5 * FL + 20);
        chk("flood_frames", 32'(done_cnt), 32'd5);
        push_word(8'h0F);
        idle(17);
        pulse_reset();
        idle(2 * FL);
        chk("post_rst_tflag", 32'(transmitting_flag), 32'd0);
        for (int i = 0; i < 1500; i++) begin
            tx_valid = (i < 700) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
            tx_data = DW'($urandom);
            if (i == 900) pulse_reset();
            @(negedge clk);
            #1;
        end
        tx_valid = 1'b0;
        idle((DEPTH + 1) * FL + 20);
        chk("drain_tflag", 32'(transmitting_flag), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
